// File: rtl/avalon_sysctrl_cmd_master.sv
// ---------------------------------------------------------------------------
// avalon_sysctrl_cmd_master
//
// Avalon-MM master that turns debug commands into single-beat read/write
// transactions on the sysctrl on-chip memory slave. The system-reset
// register sits at word address 0. Each accepted command produces exactly
// one response. Only one transaction can be outstanding at a time.
//
// Ports:
//   clk, reset_n         clock and asynchronous active-low reset
//   cmd_*                command channel (valid/ready); write flag, word
//                        address, write data and byte lanes
//   rsp_*                response channel (valid/ready); read data (0 for
//                        writes and aborts) and the timeout error flag
//   avm_*                Avalon-MM master interface with waitrequest
//   busy                 high whenever a transaction is in flight
//
// A slave that holds waitrequest high for TIMEOUT_CYCLES consecutive cycles
// is abandoned, and the response carries rsp_error. Setting TIMEOUT_CYCLES
// to 0 disables the timeout.
// ---------------------------------------------------------------------------
module avalon_sysctrl_cmd_master #(
  parameter int ADDR_W         = 8,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_W           = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [31:0]       cmd_writedata,
  input  logic [3:0]        cmd_byteenable,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_readdata,
  output logic              rsp_error,
  // Avalon-MM master
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUS    = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // Final stalled-cycle count before the abort. The counter value equals the
  // number of stalled cycles already seen. The abort therefore fires in the
  // TIMEOUT_CYCLES-th stalled cycle, and the strobes drop on the following edge.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]      LAT     = 2'(READ_LATENCY);

  logic [1:0]        state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cs_q, cs_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic              timed_out;

  assign timed_out = (TIMEOUT_CYCLES != 0) && avm_waitrequest && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    cs_d      = cs_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    to_cnt_d  = to_cnt_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d  = S_BUS;
          is_wr_d  = cmd_write;
          addr_d   = cmd_address;
          be_d     = cmd_byteenable;
          wdata_d  = cmd_writedata;
          cs_d     = 1'b1;
          rd_d     = ~cmd_write;
          wr_d     = cmd_write;
          rdata_d  = '0;
          err_d    = 1'b0;
          to_cnt_d = '0;
        end
      end
      S_BUS: begin
        // Acceptance takes priority over a timeout that expires in the same cycle.
        if (!avm_waitrequest) begin
          cs_d = 1'b0;
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (is_wr_q) begin
            state_d = S_RESP;
          end else if (READ_LATENCY == 0) begin
            rdata_d = avm_readdata;
            state_d = S_RESP;
          end else begin
            // lat_cnt counts cycles since the accepting cycle.
            lat_cnt_d = 2'd1;
            state_d   = S_RDWAIT;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (timed_out) begin
            cs_d    = 1'b0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end
        end
      end
      S_RDWAIT: begin
        if (lat_cnt_q == LAT) begin
          rdata_d   = avm_readdata;
          lat_cnt_d = 2'd0;
          state_d   = S_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The strobes are registers with async reset. A reset in mid-transaction
  // therefore drops them at once, without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      cs_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      to_cnt_q  <= '0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      to_cnt_q  <= to_cnt_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_readdata   = rdata_q;
  assign rsp_error      = err_q;
  assign avm_address    = addr_q;
  assign avm_byteenable = be_q;
  assign avm_writedata  = wdata_q;
  assign avm_chipselect = cs_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;

endmodule

// File: tb/tb_avalon_sysctrl_cmd_master.sv
// ---------------------------------------------------------------------------
// Bench for avalon_sysctrl_cmd_master (READ_LATENCY=1, TIMEOUT_CYCLES=4).
// The slave is a word memory with byte lanes, a randomized waitrequest and a
// one-cycle read latency. It drives random data on readdata whenever no read
// is being returned. A transaction-level model predicts, for every cycle,
// the outputs that the command, waitrequest and rsp_ready history allows.
// It uses its own reference memory to predict read data.
// ---------------------------------------------------------------------------
module tb_avalon_sysctrl_cmd_master;
  localparam int AW  = 8;
  localparam int L   = 1;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_address = '0;
  logic [31:0]   cmd_writedata = '0;
  logic [3:0]    cmd_byteenable = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_error;
  logic [31:0]   rsp_readdata;
  logic [AW-1:0] avm_address;
  logic [3:0]    avm_byteenable;
  logic          avm_chipselect, avm_read, avm_write;
  logic [31:0]   avm_writedata, avm_readdata = '0;
  logic          avm_waitrequest = 1'b0, busy;

  always #5 clk = ~clk;

  avalon_sysctrl_cmd_master #(.ADDR_W(AW), .READ_LATENCY(L), .TIMEOUT_CYCLES(TMO), .TO_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata), .cmd_byteenable(cmd_byteenable),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_readdata(rsp_readdata), .rsp_error(rsp_error),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_chipselect(avm_chipselect),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest), .busy(busy)
  );

  int cmp_n = 0, mis_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      mis_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    merge = old;
    for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = d[8*b +: 8];
  endfunction

  // ---------------- slave + input randomizers ----------------
  logic [31:0] smem [256];
  logic [31:0] rmem [256];
  int wr_mode = 2;   // 0 random, 1 stuck high, 2 always low
  int rr_mode = 1;   // 0 low, 1 high, 2 random

  always @(posedge clk) begin
    if (avm_chipselect && avm_write && !avm_waitrequest)
      smem[avm_address] = merge(smem[avm_address], avm_writedata, avm_byteenable);
    avm_readdata <= (avm_chipselect && avm_read && !avm_waitrequest) ? smem[avm_address] : $urandom;
  end

  always @(posedge clk) begin
    #2;
    case (wr_mode)
      0:       avm_waitrequest = ($urandom_range(0, 99) < 35);
      1:       avm_waitrequest = 1'b1;
      default: avm_waitrequest = 1'b0;
    endcase
    case (rr_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = ($urandom_range(0, 99) < 60);
    endcase
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  int          cyc = 0, rsp_count = 0, n_issued = 0;
  bit          in_fl = 0, c_w = 0, bus_done = 0, e_err = 0, rsp_seen = 0, last_err = 0;
  logic [AW-1:0] c_a;
  logic [3:0]  c_be;
  logic [31:0] c_d, e_data, last_data;
  int          stalls, gap, strobe_n, acc_cyc, last_lat, last_strobes;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      in_fl = 0;
    end else if (!in_fl) begin
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_strobes", {avm_chipselect, avm_read, avm_write}, 0);
      if (cmd_valid) begin
        in_fl = 1; c_w = cmd_write; c_a = cmd_address; c_d = cmd_writedata; c_be = cmd_byteenable;
        bus_done = 0; stalls = 0; strobe_n = 0; rsp_seen = 0; acc_cyc = cyc;
      end
    end else begin
      chk("busy_cmd_ready", cmd_ready, 0);
      chk("busy_busy", busy, 1);
      if (!bus_done) begin
        chk("bus_strobes", {avm_chipselect, avm_read, avm_write}, {1'b1, !c_w, c_w});
        chk("bus_addr", avm_address, c_a);
        chk("bus_be", avm_byteenable, c_be);
        if (c_w) chk("bus_wdata", avm_writedata, c_d);
        chk("bus_rsp_valid", rsp_valid, 0);
        strobe_n++;
        if (!avm_waitrequest) begin
          bus_done = 1; e_err = 0;
          gap = c_w ? 1 : 1 + L;
          if (c_w) begin rmem[c_a] = merge(rmem[c_a], c_d, c_be); e_data = 0; end
          else e_data = rmem[c_a];
        end else begin
          stalls++;
          if (stalls == TMO) begin bus_done = 1; e_err = 1; e_data = 0; gap = 1; end
        end
      end else begin
        chk("post_strobes", {avm_chipselect, avm_read, avm_write}, 0);
        gap--;
        if (gap > 0) begin
          chk("wait_rsp_valid", rsp_valid, 0);
        end else begin
          chk("rsp_valid", rsp_valid, 1);
          chk("rsp_data", rsp_readdata, e_data);
          chk("rsp_error", rsp_error, e_err);
          if (!rsp_seen) begin rsp_seen = 1; last_lat = cyc - acc_cyc; end
          if (rsp_ready) begin
            in_fl = 0; rsp_count++;
            last_data = rsp_readdata; last_err = rsp_error; last_strobes = strobe_n;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_cmd(input bit w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_writedata = d; cmd_byteenable = be;
    while (!cmd_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) chk("cmd_ready_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_issued++;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_count != n_issued && n < 300) begin @(posedge clk); n++; end
    if (n >= 300) chk("rsp_timeout", rsp_count, n_issued);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int saved;
    bit w;
    logic [AW-1:0] a;
    for (int i = 0; i < 256; i++) begin smem[i] = '0; rmem[i] = '0; end
    #2 reset_n = 1'b0;
    #20;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {avm_chipselect, avm_read, avm_write}, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_rsp", {rsp_error, rsp_readdata}, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // write 1 to the system-reset register
    do_cmd(1, 8'h00, 32'h1, 4'hF); wait_rsp();
    chk("sysreset_req", smem[0][0], 1);
    chk("sysreset_strobe_cycles", last_strobes, 1);
    chk("sysreset_latency", last_lat, 2);
    chk("sysreset_err", last_err, 0);

    // write then read back
    do_cmd(1, 8'h10, 32'hA5A5_1234, 4'hF); wait_rsp();
    do_cmd(0, 8'h10, 32'h0, 4'hF); wait_rsp();
    chk("readback_data", last_data, 32'hA5A5_1234);
    chk("readback_latency", last_lat, 3);

    // three waitrequest stalls on a read
    wr_mode = 1;
    do_cmd(0, 8'h10, 32'h0, 4'h3);
    repeat (3) @(posedge clk);
    #1 wr_mode = 2;
    wait_rsp();
    chk("stall_strobe_cycles", last_strobes, 4);
    chk("stall_data", last_data, 32'hA5A5_1234);
    chk("stall_latency", last_lat, 6);

    // timeout on a stuck slave, then a normal command
    wr_mode = 1;
    do_cmd(1, 8'h20, 32'hDEAD_BEEF, 4'hF); wait_rsp();
    chk("timeout_err", last_err, 1);
    chk("timeout_data", last_data, 0);
    chk("timeout_strobe_cycles", last_strobes, 4);
    chk("timeout_latency", last_lat, 5);
    chk("timeout_no_write", smem[8'h20], 0);
    wr_mode = 2;
    do_cmd(0, 8'h10, 32'h0, 4'hF); wait_rsp();
    chk("after_timeout_err", last_err, 0);
    chk("after_timeout_data", last_data, 32'hA5A5_1234);

    // response backpressure
    rr_mode = 0;
    do_cmd(1, 8'h30, 32'h0BAD_F00D, 4'h5);
    repeat (7) @(posedge clk);
    #1;
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_cmd_ready", cmd_ready, 0);
    rr_mode = 1;
    wait_rsp();
    chk("bp_memory", smem[8'h30], 32'h00AD_000D);

    // reset while the bus phase is stalled
    wr_mode = 1;
    do_cmd(0, 8'h10, 32'h0, 4'hF);
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    chk("midrst_strobes", {avm_chipselect, avm_read, avm_write}, 0);
    wr_mode = 2;
    saved = rsp_count;
    n_issued = rsp_count;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_rsp_valid", rsp_valid, 0);
    repeat (5) @(posedge clk);
    chk("midrst_no_rsp", rsp_count, saved);

    // randomized traffic
    wr_mode = 0; rr_mode = 2;
    for (int i = 0; i < 80; i++) begin
      w = $urandom_range(0, 1);
      a = 8'h40 + 8'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = 8'hFF;
      do_cmd(w, a, $urandom, 4'($urandom_range(1, 15)));
      if ($urandom_range(0, 2) == 0) wait_rsp();
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
    end
    wait_rsp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
    $finish;
  end

endmodule
